stage4_mem: RTL and testbench
=============================

STAGE4_MEM -- requirements
Module: stage4_mem

Interface
REQ-001 SHALL have parameter WIDTH_ES_TO_MS_BUS, default `WIDTH_ES_TO_MS_BUS, meaning the width of the incoming EX-to-MEM bus.
REQ-002 SHALL have parameter WIDTH_MS_TO_WS_BUS, default `WIDTH_MS_TO_WS_BUS, meaning the width of the outgoing MEM-to-WB bus.
REQ-003 SHALL have ports, one clock and reset asynchronous active-high:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- es_to_ms_valid  in  1  EX holds an instruction.
- es_to_ms_bus  in  WIDTH_ES_TO_MS_BUS  {ex_bus, mem_req, load_op[4:0], alu_result[31:0], dest[4:0], gr_we, pc[31:0]}.
- ms_allow_in  out  1  MEM accepts this cycle.
- ms_to_ws_valid  out  1  MEM offers an instruction to WB.
- ms_to_ws_bus  out  WIDTH_MS_TO_WS_BUS  {ex_bus, final_result[31:0], dest, gr_we, pc}.
- ws_allow_in  in  1  WB accepts.
- flush  in  1  wb_ex | ertn_flush | tlb_reflush from WB.
- es_kill_req  in  1  EX reports that flush killed an accepted, unanswered data request.
- data_sram_data_ok  in  1  response handshake.
- data_sram_rdata  in  32  response data.
- ms_to_ds_bus  out  39  {load_wait, we, dest[4:0], data[31:0]} forwarding to ID.

Function
REQ-004 SHALL register es_to_ms_bus into bus_reg when es_to_ms_valid && ms_allow_in.
REQ-005 SHALL update ms_valid as follows: if flush, ms_valid <= 0; else if ms_allow_in, ms_valid <= es_to_ms_valid.
REQ-006 SHALL define wait_resp = ms_valid && mem_req && !resp_buf_v.
REQ-007 SHALL define ms_ready_go = !wait_resp || (data_sram_data_ok && discard_cnt == 0).
REQ-008 SHALL define ms_allow_in = !ms_valid || (ms_ready_go && ws_allow_in).
REQ-009 SHALL define ms_to_ws_valid = ms_valid && ms_ready_go && !flush.
REQ-010 SHALL handle a response whose data_ok arrives with discard_cnt==0 and wait_resp but !ws_allow_in: latch rdata into resp_buf and set resp_buf_v.
REQ-011 SHALL clear resp_buf_v on handoff to WB or on flush.
REQ-012 SHALL maintain discard_cnt (2-bit) as follows:
- +1 when flush && wait_resp && !(data_sram_data_ok && discard_cnt==0).
- +1 when es_kill_req.
- -1 on each data_ok while discard_cnt>0.
- All three events in the same cycle SHALL sum arithmetically.
REQ-013 SHALL NOT deliver discarded responses to any instruction.
REQ-014 SHALL select load data as resp_buf_v ? resp_buf : data_sram_rdata, and extract it using offset alu_result[1:0]:
- load_op one-hot {ld.w, ld.hu, ld.h, ld.bu, ld.b}.
- Byte lane = offset*8; halfword lane = offset[1]*16.
- b/h SHALL sign-extend; bu/hu SHALL zero-extend.
REQ-015 SHALL set final_result = |load_op ? extracted : alu_result.
REQ-016 SHALL pass ex_bus through unchanged; EX guarantees mem_req=0 whenever any exception is flagged.
REQ-017 SHALL drive ms_to_ds_bus as follows:
- we = ms_valid && gr_we.
- load_wait = ms_valid && |load_op && !ms_ready_go.
- data = final_result.
REQ-018 SHALL give loads a latency of 1 cycle after data_ok when WB is stalled, and 0 additional cycles otherwise.

Reset
REQ-019 SHALL, on reset, clear ms_valid, bus_reg, resp_buf, resp_buf_v and discard_cnt to 0 immediately, without waiting for clk.
REQ-020 SHALL therefore drive, while in reset, ms_to_ws_valid=0, ms_allow_in=1 and ms_to_ds_bus=0.
REQ-021 SHALL abandon any in-flight request on reset mid-operation; the SRAM side is reset concurrently.

Structure
REQ-022 SHALL take WIDTH_ES_TO_MS_BUS, WIDTH_MS_TO_WS_BUS and the load_op bit positions from mycpu_head.vh.
REQ-023 SHALL use one sub-module, mem_load_align, containing the combinational extraction of REQ-014.

Verification
REQ-024 Bench SHALL cover: ld.b, alu_result=0x1003, rdata=0x80FF_0000, data_ok in the cycle after entry, ws_allow_in=1 -> final_result=0xFFFF_FF80, ms_to_ws_valid for exactly 1 cycle.
REQ-025 Bench SHALL cover: ld.hu at offset 2, rdata=0xBEEF_1234, ws_allow_in=0 for 3 cycles after data_ok -> resp_buf_v=1, final_result=0x0000_BEEF held stable, handoff on ws_allow_in=1.
REQ-026 Bench SHALL cover: flush while a ld.w waits, then a new ld.w enters; data_ok returns 0x1111_1111 then 0x2222_2222 -> discard_cnt goes 1->0, new load gets 0x2222_2222.
REQ-027 Bench SHALL cover: flush and es_kill_req in the same cycle with wait_resp -> discard_cnt=2; the next two data_ok are dropped.
REQ-028 Bench SHALL cover: add (no mem_req) with dest=5 behind a stalled WB -> ms_to_ds_bus we=1, dest=5, load_wait=0; ms_allow_in=0 until ws_allow_in.
REQ-029 Bench SHALL cover: reset asserted mid-wait, asynchronous to clk -> ms_valid and discard_cnt read 0 before the next clk edge.

Source files
------------

// File: rtl/stage4_mem_pkg.sv
// Shared widths and load-op bit positions for the MEM pipeline stage.
// Bus layouts are fixed-field concatenations with ex_bus at the top.
package stage4_mem_pkg;

   localparam int EX_BUS_W       = 8;
   localparam int ES_FIXED_W     = 76;   // mem_req + load_op + alu_result + dest + gr_we + pc
   localparam int MS_FIXED_W     = 70;   // final_result + dest + gr_we + pc
   localparam int ES_TO_MS_BUS_W = EX_BUS_W + ES_FIXED_W;
   localparam int MS_TO_WS_BUS_W = EX_BUS_W + MS_FIXED_W;
   localparam int MS_TO_DS_BUS_W = 39;

   localparam int LOAD_OP_W = 5;
   localparam int LD_B      = 0;
   localparam int LD_BU     = 1;
   localparam int LD_H      = 2;
   localparam int LD_HU     = 3;
   localparam int LD_W      = 4;

   function automatic logic [31:0] extend16(input logic [15:0] v, input logic sign);
      return {{16{sign & v[15]}}, v};
   endfunction

   function automatic logic [31:0] extend8(input logic [7:0] v, input logic sign);
      return {{24{sign & v[7]}}, v};
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/halfword out of a load word and sign/zero extends it.
module mem_load_align
   import stage4_mem_pkg::*;
(
   input  logic [31:0]          rdata,
   input  logic [1:0]           offset,
   input  logic [LOAD_OP_W-1:0] load_op,
   output logic [31:0]          result
);

   logic [31:0] shifted;
   logic [15:0] half_lane;

   always_comb begin
      shifted   = rdata >> {offset, 3'b000};
      half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
      result    = rdata;
      if (load_op[LD_B])
         result = extend8(shifted[7:0], 1'b1);
      else if (load_op[LD_BU])
         result = extend8(shifted[7:0], 1'b0);
      else if (load_op[LD_H])
         result = extend16(half_lane, 1'b1);
      else if (load_op[LD_HU])
         result = extend16(half_lane, 1'b0);
   end

endmodule

// File: rtl/stage4_mem.sv
// MEM pipeline stage: holds one instruction, waits for its data response,
// buffers it when WB stalls, and drops responses that belong to flushed requests.
module stage4_mem
   import stage4_mem_pkg::*;
#(
   parameter int WIDTH_ES_TO_MS_BUS = ES_TO_MS_BUS_W,
   parameter int WIDTH_MS_TO_WS_BUS = MS_TO_WS_BUS_W
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          es_to_ms_valid,
   input  logic [WIDTH_ES_TO_MS_BUS-1:0] es_to_ms_bus,
   output logic                          ms_allow_in,
   output logic                          ms_to_ws_valid,
   output logic [WIDTH_MS_TO_WS_BUS-1:0] ms_to_ws_bus,
   input  logic                          ws_allow_in,
   input  logic                          flush,
   input  logic                          es_kill_req,
   input  logic                          data_sram_data_ok,
   input  logic [31:0]                   data_sram_rdata,
   output logic [MS_TO_DS_BUS_W-1:0]     ms_to_ds_bus
);

   localparam int EXW = WIDTH_ES_TO_MS_BUS - ES_FIXED_W;

   logic [WIDTH_ES_TO_MS_BUS-1:0] bus_reg;
   logic                          ms_valid;
   logic [31:0]                   resp_buf;
   logic                          resp_buf_v;
   logic [1:0]                    discard_cnt;
   logic [1:0]                    discard_nxt;

   logic [EXW-1:0]       ex_bus;
   logic                 mem_req;
   logic [LOAD_OP_W-1:0] load_op;
   logic [31:0]          alu_result;
   logic [4:0]           dest;
   logic                 gr_we;
   logic [31:0]          pc;

   logic        resp_hit;
   logic        wait_resp;
   logic        ms_ready_go;
   logic        handoff;
   logic [31:0] load_data;
   logic [31:0] aligned;
   logic [31:0] final_result;

   assign ex_bus     = bus_reg[WIDTH_ES_TO_MS_BUS-1 -: EXW];
   assign mem_req    = bus_reg[75];
   assign load_op    = bus_reg[74:70];
   assign alu_result = bus_reg[69:38];
   assign dest       = bus_reg[37:33];
   assign gr_we      = bus_reg[32];
   assign pc         = bus_reg[31:0];

   // A response only belongs to the resident instruction once all stale ones are drained.
   assign resp_hit       = data_sram_data_ok && (discard_cnt == 2'd0);
   assign wait_resp      = ms_valid && mem_req && !resp_buf_v;
   assign ms_ready_go    = !wait_resp || resp_hit;
   assign ms_allow_in    = !ms_valid || (ms_ready_go && ws_allow_in);
   assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
   assign handoff        = ms_to_ws_valid && ws_allow_in;

   assign discard_nxt = discard_cnt
                      + 2'(flush && wait_resp && !resp_hit)
                      + 2'(es_kill_req)
                      - 2'(data_sram_data_ok && (discard_cnt != 2'd0));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ms_valid    <= 1'b0;
         bus_reg     <= '0;
         discard_cnt <= 2'd0;
      end else begin
         discard_cnt <= discard_nxt;
         if (flush)
            ms_valid <= 1'b0;
         else if (ms_allow_in)
            ms_valid <= es_to_ms_valid;
         if (es_to_ms_valid && ms_allow_in)
            bus_reg <= es_to_ms_bus;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_buf   <= 32'd0;
         resp_buf_v <= 1'b0;
      end else if (flush || handoff) begin
         resp_buf_v <= 1'b0;
      end else if (wait_resp && resp_hit && !ws_allow_in) begin
         resp_buf   <= data_sram_rdata;
         resp_buf_v <= 1'b1;
      end
   end

   assign load_data = resp_buf_v ? resp_buf : data_sram_rdata;

   mem_load_align u_align (
      .rdata   (load_data),
      .offset  (alu_result[1:0]),
      .load_op (load_op),
      .result  (aligned)
   );

   assign final_result = (|load_op) ? aligned : alu_result;
   assign ms_to_ws_bus = {ex_bus, final_result, dest, gr_we, pc};
   assign ms_to_ds_bus = {ms_valid && (|load_op) && !ms_ready_go,
                          ms_valid && gr_we,
                          dest,
                          final_result};

endmodule

// File: tb/tb_stage4_mem.sv
// Directed scenarios plus randomized traffic against a transaction-level model of the MEM stage.
module tb_stage4_mem;

   localparam int ES_W = 84;
   localparam int MS_W = 78;

   typedef struct packed {
      logic [7:0]  ex;
      logic        mem_req;
      logic [2:0]  kind;     // 0 none, 1 b, 2 bu, 3 h, 4 hu, 5 w
      logic [31:0] alu;
      logic [4:0]  dest;
      logic        gr_we;
      logic [31:0] pc;
   } instr_t;

   logic            clk;
   logic            reset;
   logic            es_to_ms_valid;
   logic [ES_W-1:0] es_to_ms_bus;
   logic            ms_allow_in;
   logic            ms_to_ws_valid;
   logic [MS_W-1:0] ms_to_ws_bus;
   logic            ws_allow_in;
   logic            flush;
   logic            es_kill_req;
   logic            data_sram_data_ok;
   logic [31:0]     data_sram_rdata;
   logic [38:0]     ms_to_ds_bus;

   int checks;
   int failures;

   stage4_mem #(.WIDTH_ES_TO_MS_BUS(ES_W), .WIDTH_MS_TO_WS_BUS(MS_W)) dut (
      .clk               (clk),
      .reset             (reset),
      .es_to_ms_valid    (es_to_ms_valid),
      .es_to_ms_bus      (es_to_ms_bus),
      .ms_allow_in       (ms_allow_in),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .ws_allow_in       (ws_allow_in),
      .flush             (flush),
      .es_kill_req       (es_kill_req),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .ms_to_ds_bus      (ms_to_ds_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] onehot(input logic [2:0] kind);
      logic [4:0] one;
      one = 5'd1;
      return (kind == 3'd0) ? 5'd0 : (one << (kind - 3'd1));
   endfunction

   function automatic logic [ES_W-1:0] es_word(input instr_t i);
      return {i.ex, i.mem_req, onehot(i.kind), i.alu, i.dest, i.gr_we, i.pc};
   endfunction

   // Architectural load result computed from byte address arithmetic.
   function automatic logic [31:0] ref_final(input instr_t i, input logic [31:0] word);
      int unsigned off, v;
      off = i.alu % 4;
      case (i.kind)
         3'd1, 3'd2: begin
            v = (word / (1 << (8 * off))) % 256;
            if (i.kind == 3'd1 && v >= 128) v = v + 32'hFFFF_FF00;
         end
         3'd3, 3'd4: begin
            v = (word / (1 << (16 * (off / 2)))) % 65536;
            if (i.kind == 3'd3 && v >= 32768) v = v + 32'hFFFF_0000;
         end
         3'd5:    v = word;
         default: v = i.alu;
      endcase
      return v;
   endfunction

   function automatic logic [MS_W-1:0] ms_word(input instr_t i, input logic [31:0] word);
      return {i.ex, ref_final(i, word), i.dest, i.gr_we, i.pc};
   endfunction

   function automatic instr_t mk(input logic mem_req, input logic [2:0] kind, input logic [31:0] alu,
                                 input logic [4:0] dest);
      instr_t i;
      i.ex = 8'h00; i.mem_req = mem_req; i.kind = kind; i.alu = alu;
      i.dest = dest; i.gr_we = 1'b1; i.pc = 32'h1C00_0000 + {27'd0, dest} * 4;
      return i;
   endfunction

   instr_t a, b;
   instr_t cur, m_instr;
   logic   cur_has, m_valid, m_done, exp_valid, exp_ready;
   logic   hand, acc;
   logic [31:0] m_rdata;

   initial begin
      checks = 0; failures = 0;
      reset = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_allow_in = 1'b1;
      flush = 1'b0; es_kill_req = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
      #2;
      chk("rst_valid", ms_to_ws_valid, 1'b0);
      chk("rst_allow", ms_allow_in, 1'b1);
      chk("rst_ds_bus", ms_to_ds_bus, 39'd0);
      next_cycle();
      reset = 1'b0;
      next_cycle();

      // ld.b at offset 3, response one cycle after entry
      a = mk(1'b1, 3'd1, 32'h1003, 5'd3);
      es_to_ms_valid = 1'b1; es_to_ms_bus = es_word(a);
      #4 chk("ldb_allow", ms_allow_in, 1'b1);
      next_cycle();
      es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_0000;
      #4 chk("ldb_valid", ms_to_ws_valid, 1'b1);
      chk("ldb_final", ms_to_ws_bus[69:38], 32'hFFFF_FF80);
      chk("ldb_bus", ms_to_ws_bus, ms_word(a, 32'h80FF_0000));
      next_cycle();
      data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
      #4 chk("ldb_one_cycle", ms_to_ws_valid, 1'b0);
      next_cycle();

      // ld.hu at offset 2 with WB stalled after data_ok
      a = mk(1'b1, 3'd4, 32'h2002, 5'd7);
      es_to_ms_valid = 1'b1; es_to_ms_bus = es_word(a);
      next_cycle();
      es_to_ms_valid = 1'b0; ws_allow_in = 1'b0;
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBEEF_1234;
      #4 chk("ldhu_valid", ms_to_ws_valid, 1'b1);
      chk("ldhu_final", ms_to_ws_bus[69:38], 32'h0000_BEEF);
      next_cycle();
      data_sram_data_ok = 1'b0;
      for (int k = 0; k < 3; k++) begin
         data_sram_rdata = $urandom;
         #4 chk("ldhu_buf_v", dut.resp_buf_v, 1'b1);
         chk("ldhu_hold", ms_to_ws_bus[69:38], 32'h0000_BEEF);
         chk("ldhu_stall", ms_allow_in, 1'b0);
         next_cycle();
      end
      ws_allow_in = 1'b1;
      #4 chk("ldhu_hand_valid", ms_to_ws_valid, 1'b1);
      chk("ldhu_hand_bus", ms_to_ws_bus, ms_word(a, 32'hBEEF_1234));
      next_cycle();
      #4 chk("ldhu_buf_clr", dut.resp_buf_v, 1'b0);
      next_cycle();

      // flush of a waiting ld.w, stale response dropped, next ld.w served
      a = mk(1'b1, 3'd5, 32'h3000, 5'd9);
      es_to_ms_valid = 1'b1; es_to_ms_bus = es_word(a);
      next_cycle();
      es_to_ms_valid = 1'b0;
      #4 chk("ldw_load_wait", ms_to_ds_bus[38], 1'b1);
      chk("ldw_wait_valid", ms_to_ws_valid, 1'b0);
      chk("ldw_wait_allow", ms_allow_in, 1'b0);
      next_cycle();
      flush = 1'b1;
      #4 chk("flush_valid", ms_to_ws_valid, 1'b0);
      next_cycle();
      flush = 1'b0;
      chk("flush_discard", dut.discard_cnt, 2'd1);
      b = mk(1'b1, 3'd5, 32'h3004, 5'd10);
      es_to_ms_valid = 1'b1; es_to_ms_bus = es_word(b);
      #4 chk("flush_allow", ms_allow_in, 1'b1);
      next_cycle();
      es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
      #4 chk("stale_dropped", ms_to_ws_valid, 1'b0);
      next_cycle();
      chk("discard_drained", dut.discard_cnt, 2'd0);
      data_sram_rdata = 32'h2222_2222;
      #4 chk("fresh_valid", ms_to_ws_valid, 1'b1);
      chk("fresh_bus", ms_to_ws_bus, ms_word(b, 32'h2222_2222));
      next_cycle();
      data_sram_data_ok = 1'b0;

      // flush and EX kill together leave two responses to drop
      a = mk(1'b1, 3'd5, 32'h3008, 5'd11);
      es_to_ms_valid = 1'b1; es_to_ms_bus = es_word(a);
      next_cycle();
      es_to_ms_valid = 1'b0; flush = 1'b1; es_kill_req = 1'b1;
      next_cycle();
      flush = 1'b0; es_kill_req = 1'b0;
      chk("dual_discard", dut.discard_cnt, 2'd2);
      b = mk(1'b1, 3'd3, 32'h4000, 5'd12);
      es_to_ms_valid = 1'b1; es_to_ms_bus = es_word(b);
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_0001;
      #4 chk("dual_allow", ms_allow_in, 1'b1);
      next_cycle();
      es_to_ms_valid = 1'b0; data_sram_rdata = 32'hDEAD_0002;
      #4 chk("dual_drop2", ms_to_ws_valid, 1'b0);
      chk("dual_cnt1", dut.discard_cnt, 2'd1);
      next_cycle();
      data_sram_rdata = 32'h0000_8001;
      #4 chk("dual_valid", ms_to_ws_valid, 1'b1);
      chk("dual_bus", ms_to_ws_bus, ms_word(b, 32'h0000_8001));
      next_cycle();
      data_sram_data_ok = 1'b0;

      // ALU op behind stalled WB forwards to ID
      ws_allow_in = 1'b0;
      a = mk(1'b0, 3'd0, 32'h55, 5'd5);
      es_to_ms_valid = 1'b1; es_to_ms_bus = es_word(a);
      next_cycle();
      es_to_ms_valid = 1'b0;
      #4 chk("add_ds_bus", ms_to_ds_bus, {1'b0, 1'b1, 5'd5, 32'h55});
      chk("add_allow0", ms_allow_in, 1'b0);
      chk("add_valid", ms_to_ws_valid, 1'b1);
      next_cycle();
      #4 chk("add_allow1", ms_allow_in, 1'b0);
      next_cycle();
      ws_allow_in = 1'b1;
      #4 chk("add_release", ms_allow_in, 1'b1);
      next_cycle();
      #4 chk("add_gone", dut.ms_valid, 1'b0);
      next_cycle();

      // asynchronous reset during a wait with a pending discard
      a = mk(1'b1, 3'd5, 32'h5000, 5'd13);
      es_to_ms_valid = 1'b1; es_to_ms_bus = es_word(a);
      next_cycle();
      es_to_ms_valid = 1'b0; es_kill_req = 1'b1;
      next_cycle();
      es_kill_req = 1'b0;
      #1 chk("pre_rst_cnt", dut.discard_cnt, 2'd1);
      chk("pre_rst_valid", dut.ms_valid, 1'b1);
      #2 reset = 1'b1;
      #1 chk("arst_valid", dut.ms_valid, 1'b0);
      chk("arst_cnt", dut.discard_cnt, 2'd0);
      chk("arst_out_valid", ms_to_ws_valid, 1'b0);
      chk("arst_allow", ms_allow_in, 1'b1);
      chk("arst_ds_bus", ms_to_ds_bus, 39'd0);
      next_cycle();
      reset = 1'b0;
      next_cycle();

      // randomized traffic, one response per memory instruction, no flushes
      cur_has = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_rdata = 32'd0;
      cur = '0; m_instr = '0;
      for (int n = 0; n < 600; n++) begin
         if (!cur_has && ($urandom_range(0, 3) != 0)) begin
            cur.kind    = 3'($urandom_range(0, 5));
            cur.mem_req = (cur.kind != 3'd0) ? 1'b1 : 1'($urandom_range(0, 1));
            cur.ex      = cur.mem_req ? 8'h00 : 8'($urandom);
            cur.alu     = $urandom;
            cur.dest    = 5'($urandom);
            cur.gr_we   = 1'($urandom);
            cur.pc      = $urandom;
            cur_has     = 1'b1;
         end
         es_to_ms_valid = cur_has;
         es_to_ms_bus   = cur_has ? es_word(cur) : ES_W'($urandom);
         ws_allow_in    = ($urandom_range(0, 9) < 7);
         data_sram_data_ok = m_valid && m_instr.mem_req && !m_done && ($urandom_range(0, 1) == 1);
         data_sram_rdata   = data_sram_data_ok ? m_rdata : $urandom;
         #4;
         exp_ready = !m_instr.mem_req || m_done || data_sram_data_ok;
         exp_valid = m_valid && exp_ready;
         chk("rnd_valid", ms_to_ws_valid, exp_valid);
         chk("rnd_allow", ms_allow_in, !m_valid || (exp_ready && ws_allow_in));
         chk("rnd_ds_ctl", ms_to_ds_bus[38:37],
             {m_valid && (m_instr.kind != 3'd0) && !exp_ready, m_valid && m_instr.gr_we});
         hand = ms_to_ws_valid && ws_allow_in;
         acc  = es_to_ms_valid && ms_allow_in;
         if (hand) chk("rnd_bus", ms_to_ws_bus, ms_word(m_instr, m_rdata));
         if (data_sram_data_ok) m_done = 1'b1;
         if (exp_valid && ws_allow_in) m_valid = 1'b0;
         if (acc) begin
            m_valid = 1'b1; m_instr = cur; m_done = 1'b0; m_rdata = $urandom; cur_has = 1'b0;
         end
         next_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
